// File: rtl/rv_pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, the NOP encoding and the default reset vector.
package rv_pipeline_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } ifu_state_e;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Fetch PC register: loads next_i when ld_en_i is set, returns to RESET_VECTOR on reset.
module pc_register
  import rv_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_en_i,
  input  logic [31:0] next_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_VECTOR;
    end else if (ld_en_i) begin
      pc_q <= next_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit with stall hold buffer and branch redirect/discard handling.
// Optional misaligned-branch trap enabled by defining IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit
  import rv_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic [31:0] PC,
  output logic [31:0] PC_incremented_by_4,
  output logic [31:0] Instruction,
  output logic        instr_valid
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d, pc4_q, pc4_d, instr_q, instr_d;
  logic        vld_q, vld_d;
  logic [31:0] hold_q, hold_d, tgt_q, tgt_d;
  logic [31:0] fetch_pc, pc_nxt, br_tgt, word;
  logic        pc_ld, present, trapped, br_mis;

`ifdef IFU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign trapped          = mis_q;
  assign br_mis           = |branch_target[1:0];
  assign br_tgt           = branch_target;
  assign fetch_misaligned = mis_q;
`else
  assign trapped = 1'b0;
  assign br_mis  = 1'b0;
  assign br_tgt  = word_align(branch_target);
`endif

  pc_register #(.RESET_VECTOR(RESET_VECTOR)) u_pc_register (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .ld_en_i (pc_ld),
    .next_i  (pc_nxt),
    .pc_o    (fetch_pc)
  );

  assign imem_read    = (state_q != HOLD);
  assign imem_address = fetch_pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    vld_d   = stall ? vld_q : 1'b0;
    hold_d  = hold_q;
    tgt_d   = tgt_q;
    pc_ld   = 1'b0;
    pc_nxt  = fetch_pc;
    present = 1'b0;
    word    = hold_q;
`ifdef IFU_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    if (trapped) begin
      state_d = HOLD;
      vld_d   = 1'b0;
    end else if (branch_taken) begin
      // Redirect wins over stall; any word completing now or held is dropped.
      vld_d = 1'b0;
      if (br_mis) begin
`ifdef IFU_MISALIGN_TRAP_EN
        mis_d = 1'b1;
`endif
        state_d = HOLD;
      end else if (imem_read && imem_busywait) begin
        state_d = DISCARD;
        tgt_d   = br_tgt;
      end else begin
        pc_ld   = 1'b1;
        pc_nxt  = br_tgt;
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH, WAIT: begin
          if (imem_busywait) begin
            state_d = WAIT;
          end else if (stall) begin
            hold_d  = imem_readdata;
            state_d = HOLD;
          end else begin
            present = 1'b1;
            word    = imem_readdata;
          end
        end
        DISCARD: begin
          if (!imem_busywait) begin
            pc_ld   = 1'b1;
            pc_nxt  = tgt_q;
            state_d = FETCH;
          end
        end
        HOLD: begin
          present = !stall;
        end
        default: state_d = FETCH;
      endcase
      if (present) begin
        pc_d    = fetch_pc;
        pc4_d   = fetch_pc + 32'd4;
        instr_d = word;
        vld_d   = 1'b1;
        pc_ld   = 1'b1;
        pc_nxt  = fetch_pc + 32'd4;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= FETCH;
      pc_q    <= 32'h0;
      pc4_q   <= 32'h0;
      instr_q <= NOP_INSTR;
      vld_q   <= 1'b0;
      hold_q  <= 32'h0;
      tgt_q   <= 32'h0;
`ifdef IFU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
      tgt_q   <= tgt_d;
`ifdef IFU_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign PC                  = pc_q;
  assign PC_incremented_by_4 = pc4_q;
  assign Instruction         = instr_q;
  assign instr_valid         = vld_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit against a combinational instruction memory.
module tb_instruction_fetch_unit;
  import rv_pipeline_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_busywait = 1'b0;
  logic        imem_read;
  logic [31:0] imem_address, imem_readdata;
  logic [31:0] PC, PC4, Instruction;
  logic        instr_valid;
`ifdef IFU_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h8) ? 32'h00A0_0093 : (a ^ 32'h5A00_0013);
  endfunction

  assign imem_readdata = mem_word(imem_address);

  instruction_fetch_unit dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .stall               (stall),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .imem_read           (imem_read),
    .imem_address        (imem_address),
    .imem_readdata       (imem_readdata),
    .imem_busywait       (imem_busywait),
    .PC                  (PC),
    .PC_incremented_by_4 (PC4),
    .Instruction         (Instruction),
    .instr_valid         (instr_valid)
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned    (fetch_misaligned)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock; every newly presented word is popped from the scoreboard and compared.
  task automatic tick();
    logic        upd;
    logic [31:0] p;
    @(posedge CLK);
    upd = !stall && !RESET;
    @(negedge CLK);
    if (upd && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_word", PC, 32'hFFFF_FFFF);
      end else begin
        p = exp_q.pop_front();
        check_eq("sb_pc", PC, p);
        check_eq("sb_pc4", PC4, p + 32'd4);
        check_eq("sb_instr", Instruction, mem_word(p));
      end
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    imem_busywait = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    do_reset();
    check_eq("rst_pc", PC, 32'h0);
    check_eq("rst_pc4", PC4, 32'h0);
    check_eq("rst_instr", Instruction, NOP_INSTR);
    check_eq("rst_valid", 32'(instr_valid), 32'h0);
    check_eq("rst_read", 32'(imem_read), 32'h1);
    check_eq("rst_addr", imem_address, 32'h0);

    // Zero-wait streaming: 0, 4, 8 on consecutive cycles
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    repeat (3) tick();
    check_eq("stream_drain", 32'(exp_q.size()), 32'h0);

    // Busywait for three cycles at PC=8
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    repeat (2) tick();
    imem_busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("wait_addr", imem_address, 32'h8);
      check_eq("wait_read", 32'(imem_read), 32'h1);
      tick();
      check_eq("wait_bubble", 32'(instr_valid), 32'h0);
    end
    imem_busywait = 1'b0;
    exp_q.push_back(32'h8);
    tick();
    check_eq("wait_word", Instruction, 32'h00A0_0093);

    // Stall as the word at C completes, then release
    stall = 1'b1;
    tick();
    check_eq("stall_pc", PC, 32'h8);
    check_eq("stall_valid", 32'(instr_valid), 32'h1);
    check_eq("hold_read", 32'(imem_read), 32'h0);
    tick();
    check_eq("hold_read2", 32'(imem_read), 32'h0);
    check_eq("stall_pc2", PC, 32'h8);
    stall = 1'b0;
    exp_q.push_back(32'hC);
    tick();
    check_eq("post_hold_addr", imem_address, 32'h10);

    // Branch during WAIT at 0x10 -> discard then fetch 0x100
    imem_busywait = 1'b1;
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    check_eq("disc_valid", 32'(instr_valid), 32'h0);
    check_eq("disc_addr", imem_address, 32'h10);
    check_eq("disc_read", 32'(imem_read), 32'h1);
    tick();
    imem_busywait = 1'b0;
    tick();
    check_eq("disc_drop_valid", 32'(instr_valid), 32'h0);
    check_eq("disc_tgt_addr", imem_address, 32'h100);
    exp_q.push_back(32'h100);
    tick();

    // Branch together with stall
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    tick();
    check_eq("brstall_valid", 32'(instr_valid), 32'h0);
    check_eq("brstall_addr", imem_address, 32'h40);
    check_eq("brstall_read", 32'(imem_read), 32'h1);
    stall = 1'b0;
    branch_taken = 1'b0;
    exp_q.push_back(32'h40);
    tick();

    // Branch while a word sits in the hold buffer drops that word
    stall = 1'b1;
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    stall = 1'b0;
    check_eq("holdbr_valid", 32'(instr_valid), 32'h0);
    check_eq("holdbr_addr", imem_address, 32'h200);
    exp_q.push_back(32'h200);
    tick();

    // PC wrap at the top of the address space
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    tick();
    tick();

    // Misaligned branch target
    branch_taken = 1'b1;
    branch_target = 32'h102;
    tick();
    branch_taken = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      check_eq("mis_flag", 32'(fetch_misaligned), 32'h1);
      check_eq("mis_read", 32'(imem_read), 32'h0);
      check_eq("mis_valid", 32'(instr_valid), 32'h0);
      tick();
    end
    do_reset();
    check_eq("mis_cleared", 32'(fetch_misaligned), 32'h0);
    check_eq("mis_rst_read", 32'(imem_read), 32'h1);
`else
    check_eq("mis_align_addr", imem_address, 32'h100);
    exp_q.push_back(32'h100);
    tick();
`endif

    check_eq("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the PC loaded on reset.
REQ-002 SHALL have port CLK  input  1  the single clock; every state change occurs on its rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  from the hazard unit; holds the fetch outputs and the PC.
REQ-005 SHALL have port branch_taken  input  1  single-cycle redirect request from EX.
REQ-006 SHALL have port branch_target  input  32  redirect PC, valid while branch_taken=1.
REQ-007 SHALL have port imem_read  output  1  instruction-memory read request.
REQ-008 SHALL have port imem_address  output  32  word-aligned fetch address.
REQ-009 SHALL have port imem_readdata  input  32  instruction word, valid when imem_read=1 and imem_busywait=0.
REQ-010 SHALL have port imem_busywait  input  1  memory not ready; the request must be held.
REQ-011 SHALL have ports PC, PC_incremented_by_4 and Instruction, each output, 32 bits, registered, feeding the IF/ID register.
REQ-012 SHALL have port instr_valid  output  1  high when Instruction is a real fetched word, low for a bubble.

Function
REQ-013 SHALL use FSM states FETCH, WAIT, DISCARD and HOLD.
REQ-014 In FETCH and WAIT, SHALL drive imem_read=1 and imem_address=fetch_pc; after a redirect or reset, the next request SHALL use the new PC.
REQ-015 FETCH with imem_busywait=1 SHALL go to WAIT; WAIT SHALL remain until imem_busywait=0.
REQ-016 A completed read (busywait=0) with stall=0 SHALL register PC=fetch_pc, PC_incremented_by_4=fetch_pc+4, Instruction=imem_readdata and instr_valid=1 at the next edge.
REQ-017 On the completed read in REQ-016, SHALL set fetch_pc to fetch_pc+4 (mod 2^32, wrapping silently) and SHALL go to FETCH.
REQ-018 Fetch latency SHALL be 1 cycle from the completing read cycle to valid outputs, giving a throughput of 1 instruction per cycle with zero-wait memory.
REQ-019 A completed read while stall=1 SHALL capture the word into an internal hold buffer and go to HOLD; outputs SHALL be unchanged.
REQ-020 HOLD SHALL keep imem_read=0, and on stall=0 SHALL present the buffered word per REQ-016 and return to FETCH.
REQ-021 stall=1 with no new word SHALL hold PC, PC_incremented_by_4, Instruction and instr_valid unchanged.
REQ-022 branch_taken SHALL override stall, set fetch_pc=branch_target and force instr_valid=0 at the next edge.
REQ-023 branch_taken SHALL drop any word that is in the hold buffer or completing in the same cycle.
REQ-024 branch_taken during WAIT with busywait=1 SHALL go to DISCARD.
REQ-025 DISCARD SHALL keep imem_read=1 at the old address until busywait=0, SHALL drop that word, and SHALL then go to FETCH at the target.
REQ-026 A second branch_taken while in DISCARD SHALL overwrite the target, keeping only the latest.
REQ-027 instr_valid SHALL be 0 in every cycle where no new word is presented and stall=0, so that bubbles are explicit.

Reset
REQ-028 RESET=1 at an edge SHALL force state=FETCH, fetch_pc=RESET_VECTOR, PC=0, PC_incremented_by_4=0, Instruction=32'h0000_0013 (NOP), instr_valid=0, and SHALL clear the hold buffer; RESET SHALL override branch_taken and stall.
REQ-029 RESET asserted during WAIT SHALL abandon the outstanding request; no discard tracking SHALL be required.

Configuration
REQ-030 Macro IFU_MISALIGN_TRAP_EN, when defined, SHALL add output fetch_misaligned (1 bit).
REQ-031 With IFU_MISALIGN_TRAP_EN defined, a branch_target with bits [1:0]≠0 SHALL set fetch_misaligned=1 sticky until reset, and the unit SHALL stop issuing reads (state HOLD, instr_valid=0).
REQ-032 Without IFU_MISALIGN_TRAP_EN, SHALL clear branch_target[1:0] to 0 and SHALL provide no fetch_misaligned port.

Structure
REQ-033 SHALL place the FSM state enum, NOP_INSTR=32'h0000_0013 and the default reset vector in the shared package rv_pipeline_pkg.
REQ-034 SHALL implement the PC register as sub-module pc_register (fields: load-enable, next value, RESET_VECTOR).

Verification
REQ-035 After reset with zero-wait memory, cycles 1-3 SHALL show PC=0,4,8, each with instr_valid=1 and the matching imem_readdata.
REQ-036 busywait=1 for 3 cycles at PC=8 SHALL hold imem_address=8 throughout; data 32'h00A00093 SHALL appear 1 cycle after busywait falls.
REQ-037 stall=1 as the word at PC=C completes SHALL keep the outputs at PC=8; releasing stall SHALL present PC=C with no memory re-read.
REQ-038 branch_taken with target 0x100 during WAIT at PC=0x10 SHALL drop the 0x10 word (instr_valid=0); the next read SHALL be at 0x100.
REQ-039 Simultaneous branch_taken and stall (target 0x40) SHALL produce the next request at 0x40 with instr_valid=0.
REQ-040 With IFU_MISALIGN_TRAP_EN, target 0x102 SHALL give fetch_misaligned=1 and imem_read=0 until reset; without the macro, the fetch SHALL go to 0x100.
